// File: rtl/cnn_seq_ctrl_pkg.sv
// Shared parameters and types for the cnn_top sequencer.
//   IP_DATA_WIDTH : pixel / coefficient width; cnn result is twice this width, signed
//   IFMAP_SIZE    : image edge length (image = IFMAP_SIZE^2 beats)
//   FILTER_SIZE   : filter edge length (filter = FILTER_SIZE^2 beats), must not exceed IFMAP_SIZE
package cnn_seq_ctrl_pkg;

  localparam int unsigned IP_DATA_WIDTH = 8;
  localparam int unsigned IFMAP_SIZE    = 5;
  localparam int unsigned FILTER_SIZE   = 3;
  localparam int unsigned OP_DATA_WIDTH = 2 * IP_DATA_WIDTH;

  // Row/col counters are sized for the larger (image) edge and shared with the filter load.
  localparam int unsigned RC_WIDTH  = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;
  localparam int unsigned FLT_AW    = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IMG,
    LOAD_FLT,
    SETTLE,
    UPD_WTS,
    WAIT_FC,
    HOLD
  } seq_state_e;

  // Last row/col index of the array currently being streamed in.
  function automatic logic [RC_WIDTH-1:0] edge_lim(input seq_state_e st);
    return (st == LOAD_FLT) ? RC_WIDTH'(FILTER_SIZE - 1) : RC_WIDTH'(IFMAP_SIZE - 1);
  endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// Raster-order row/col address generator.
// EDGE sizes the counters (largest array edge served); lim selects the active edge - 1, so one
// instance can walk arrays of different sizes back to back.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   en   : advance one position (one accepted beat)
//   clr  : synchronous return to [0][0], dominates en
//   lim  : last valid row/col index of the current array
//   row  : current row
//   col  : current column
//   last : current position is the final [lim][lim] element
module raster_addr_gen #(
  parameter int unsigned EDGE = 5,
  parameter int unsigned AW   = (EDGE > 1) ? $clog2(EDGE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [AW-1:0] lim,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          last
);

  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] col_q, col_d;
  logic          col_wrap;

  assign col_wrap = (col_q == lim);
  assign last     = col_wrap && (row_q == lim);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (last) begin
        // Wrap to origin so the next array starts at [0][0] without an explicit clear.
        row_d = '0;
        col_d = '0;
      end else if (col_wrap) begin
        row_d = row_q + 1'b1;
        col_d = '0;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/cnn_seq_ctrl.sv
// Sequencer for the cnn_top datapath: loads one image and one filter from a serial pixel stream,
// pulses update_wts, waits (bounded) for op_data_valid, captures cnn_out and offers it over a
// valid/ready handshake.
//   clk, rst            : clock, asynchronous active-low reset
//   start               : begin a frame (sampled only in IDLE)
//   pix_valid/pix_ready : pixel stream handshake, pix_data carries image then filter in raster order
//   ifmap_buf/filter_buf: buffered arrays for cnn_top
//   update_wts          : single-cycle launch pulse for the fully connected stage
//   op_data_valid/cnn_out: cnn_top result
//   res_valid/res_ready/res_data: result handshake
//   busy                : not IDLE
//   err_timeout         : sticky, set when op_data_valid never came; cleared by the next start
module cnn_seq_ctrl
  import cnn_seq_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic                                                       start,
  input  logic                                                       pix_valid,
  output logic                                                       pix_ready,
  input  logic [IP_DATA_WIDTH-1:0]                                   pix_data,
  output logic [IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][IP_DATA_WIDTH-1:0]   ifmap_buf,
  output logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][IP_DATA_WIDTH-1:0] filter_buf,
  output logic                                                       update_wts,
  input  logic                                                       op_data_valid,
  input  logic [OP_DATA_WIDTH-1:0]                                   cnn_out,
  output logic                                                       res_valid,
  input  logic                                                       res_ready,
  output logic [OP_DATA_WIDTH-1:0]                                   res_data,
  output logic                                                       busy,
  output logic                                                       err_timeout
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_e state_q, state_d;

  logic [RC_WIDTH-1:0] row, col;
  logic                last;
  logic                beat;
  logic                wait_done;

  logic [IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][IP_DATA_WIDTH-1:0]   ifmap_q;
  logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][IP_DATA_WIDTH-1:0] filter_q;
  logic [OP_DATA_WIDTH-1:0]                                   res_q;
  logic [WAIT_W-1:0]                                          wait_q;
  logic                                                       err_q;

  assign beat      = pix_valid && pix_ready;
  assign wait_done = (wait_q == WAIT_W'(TIMEOUT - 1));

  raster_addr_gen #(
    .EDGE (IFMAP_SIZE)
  ) u_addr (
    .clk  (clk),
    .rst  (rst),
    .en   (beat),
    .clr  (state_q == IDLE),
    .lim  (edge_lim(state_q)),
    .row  (row),
    .col  (col),
    .last (last)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = LOAD_IMG;
      LOAD_IMG: if (beat && last) state_d = LOAD_FLT;
      LOAD_FLT: if (beat && last) state_d = SETTLE;
      SETTLE:   state_d = UPD_WTS;
      UPD_WTS:  state_d = WAIT_FC;
      // A capture on the final wait cycle takes priority over the abort.
      WAIT_FC: begin
        if (op_data_valid)  state_d = HOLD;
        else if (wait_done) state_d = IDLE;
      end
      HOLD:     if (res_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    pix_ready  = 1'b0;
    update_wts = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      IDLE:               busy       = 1'b0;
      LOAD_IMG, LOAD_FLT: pix_ready  = 1'b1;
      UPD_WTS:            update_wts = 1'b1;
      HOLD:               res_valid  = 1'b1;
      default:            ;
    endcase
  end

  // Buffers, wait counter, result and error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifmap_q  <= '0;
      filter_q <= '0;
      res_q    <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == LOAD_IMG && beat) begin
        ifmap_q[row][col] <= pix_data;
      end
      if (state_q == LOAD_FLT && beat) begin
        filter_q[row[FLT_AW-1:0]][col[FLT_AW-1:0]] <= pix_data;
      end
      if (state_q == UPD_WTS) begin
        wait_q <= '0;
      end else if (state_q == WAIT_FC) begin
        wait_q <= wait_q + 1'b1;
      end
      if (state_q == WAIT_FC && op_data_valid) begin
        res_q <= cnn_out;
      end
      if (state_q == IDLE && start) begin
        err_q <= 1'b0;
      end else if (state_q == WAIT_FC && !op_data_valid && wait_done) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ifmap_buf   = ifmap_q;
  assign filter_buf  = filter_q;
  assign res_data    = res_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
module tb_cnn_seq_ctrl;
  import cnn_seq_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst, start, pix_valid, pix_ready, update_wts, op_data_valid;
  logic res_valid, res_ready, busy, err_timeout;
  logic [IP_DATA_WIDTH-1:0]                                   pix_data;
  logic [IFMAP_SIZE-1:0][IFMAP_SIZE-1:0][IP_DATA_WIDTH-1:0]   ifmap_buf;
  logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][IP_DATA_WIDTH-1:0] filter_buf;
  logic [OP_DATA_WIDTH-1:0]                                   cnn_out, res_data;

  int checks = 0;
  int errors = 0;
  logic [OP_DATA_WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;

  cnn_seq_ctrl #(.TIMEOUT(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .ifmap_buf     (ifmap_buf),
    .filter_buf    (filter_buf),
    .update_wts    (update_wts),
    .op_data_valid (op_data_valid),
    .cnn_out       (cnn_out),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .busy          (busy),
    .err_timeout   (err_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard and compare against the held result.
  task automatic check_result(input string tag);
    logic [OP_DATA_WIDTH-1:0] e;
    check({tag, "_sb_nonempty"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, res_data, e);
    end
  endtask

  // Count buffer elements that differ from the raster sequence img_base+i / flt_base+i.
  function automatic int buf_mismatch(input int img_base, input int flt_base);
    int bad = 0;
    for (int r = 0; r < IFMAP_SIZE; r++)
      for (int c = 0; c < IFMAP_SIZE; c++)
        if (ifmap_buf[r][c] !== 8'(img_base + r * IFMAP_SIZE + c)) bad++;
    for (int r = 0; r < FILTER_SIZE; r++)
      for (int c = 0; c < FILTER_SIZE; c++)
        if (filter_buf[r][c] !== 8'(flt_base + r * FILTER_SIZE + c)) bad++;
    return bad;
  endfunction

  // Start a frame, stream image+filter, and check the update_wts timing. Returns one cycle after
  // the update_wts pulse (first WAIT_FC cycle).
  task automatic load_frame(input int img_base, input int flt_base, input bit toggle,
                            input bit inject, output int idle);
    int cyc, idx, upd_at, early;
    bit v, rdy;
    idle = 0; idx = 0; upd_at = -1; early = 0;
    start = 1'b1;
    tick();
    cyc = 1;
    start = 1'b0;
    check("err_clear_on_start", err_timeout, 0);
    while (idx < 34 && cyc < 200) begin
      v = toggle ? ((cyc % 2) == 1) : 1'b1;
      pix_valid = v;
      pix_data  = (idx < 25) ? 8'(img_base + idx) : 8'(flt_base + idx - 25);
      if (inject && idx == 28) begin
        start = 1'b1; op_data_valid = 1'b1; cnn_out = 16'h7777;
      end
      rdy = pix_ready;
      if (update_wts) early++;
      tick();
      cyc++;
      start = 1'b0; op_data_valid = 1'b0;
      if (v && rdy) idx++;
      else idle++;
    end
    pix_valid = 1'b0;
    check("all_beats_taken", idx, 34);
    check("no_early_update", early, 0);
    for (int k = 0; k < 10 && upd_at < 0; k++) begin
      if (update_wts) upd_at = cyc;
      else begin
        tick();
        cyc++;
      end
    end
    check("update_wts_cycle", upd_at, 36 + idle);
    tick();
    check("update_wts_one_cycle", update_wts, 0);
  endtask

  initial begin
    int idle;
    bit seen;
    rst = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    op_data_valid = 1'b0; cnn_out = '0; res_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_update_wts", update_wts, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_err", err_timeout, 0);
    check("rst_res_data", res_data, 0);
    check("rst_ifmap_zero", |ifmap_buf, 0);
    check("rst_filter_zero", |filter_buf, 0);
    rst = 1'b1;
    tick();

    // 1: reset in the middle of the image load
    start = 1'b1;
    tick();
    start = 1'b0;
    pix_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pix_data = 8'(200 + i);
      tick();
    end
    check("partial_first_pixel", ifmap_buf[0][0], 200);
    check("partial_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_pix_ready", pix_ready, 0);
    check("midrst_ifmap_zero", |ifmap_buf, 0);
    pix_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // 2: full-rate frame, restart at [0][0]
    load_frame(1, 1, 1'b0, 1'b0, idle);
    check("f2_ifmap00", ifmap_buf[0][0], 1);
    check("f2_ifmap44", ifmap_buf[4][4], 25);
    check("f2_ifmap12", ifmap_buf[1][2], 8);
    check("f2_filter22", filter_buf[2][2], 9);
    check("f2_filter10", filter_buf[1][0], 4);
    check("f2_all", buf_mismatch(1, 1), 0);

    // 4: result 3 cycles after update_wts, held under backpressure
    tick();
    tick();
    op_data_valid = 1'b1; cnn_out = 16'hFF9C;
    exp_q.push_back(16'hFF9C);
    tick();
    op_data_valid = 1'b0; cnn_out = '0;
    check("f4_res_valid", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      // 6: start and op_data_valid in HOLD must be ignored
      if (i == 2) begin
        start = 1'b1; op_data_valid = 1'b1; cnn_out = 16'h1111;
      end
      tick();
      start = 1'b0; op_data_valid = 1'b0;
      check("f4_hold_valid", res_valid, 1);
      check("f4_hold_data", res_data, 16'hFF9C);
    end
    res_ready = 1'b1;
    check_result("f4_result");
    tick();
    res_ready = 1'b0;
    check("f4_released", res_valid, 0);
    check("f4_idle", busy, 0);

    // 3: stalled stream with stray start/op_data_valid during LOAD_FLT
    load_frame(101, 51, 1'b1, 1'b1, idle);
    check("f3_idle_cycles", idle, 33);
    check("f3_all", buf_mismatch(101, 51), 0);
    check("f3_res_untouched", res_data, 16'hFF9C);
    res_ready = 1'b1;
    op_data_valid = 1'b1; cnn_out = 16'h8001;
    exp_q.push_back(16'h8001);
    tick();
    op_data_valid = 1'b0;
    check("f3_res_valid", res_valid, 1);
    check_result("f3_result");
    tick();
    res_ready = 1'b0;
    check("f3_released", res_valid, 0);
    check("f3_idle", busy, 0);

    // 5: timeout
    load_frame(7, 3, 1'b0, 1'b0, idle);
    seen = 1'b0;
    for (int i = 0; i < 63; i++) begin
      if (res_valid) seen = 1'b1;
      tick();
    end
    check("f5_still_waiting", busy, 1);
    check("f5_no_err_yet", err_timeout, 0);
    tick();
    if (res_valid) seen = 1'b1;
    check("f5_abort_idle", busy, 0);
    check("f5_err", err_timeout, 1);
    check("f5_no_res_valid", seen, 0);
    check("f5_res_untouched", res_data, 16'h8001);

    // Capture on the last wait cycle beats the abort; start also clears err_timeout
    load_frame(9, 4, 1'b0, 1'b0, idle);
    repeat (63) tick();
    op_data_valid = 1'b1; cnn_out = 16'h0042;
    exp_q.push_back(16'h0042);
    tick();
    op_data_valid = 1'b0;
    check("edge_res_valid", res_valid, 1);
    check("edge_no_err", err_timeout, 0);
    check_result("edge_result");
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("edge_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
